// File: rtl/uart_rx_ext.sv
// uart_rx_ext: oversampled UART receiver with parity, stop-bit checks, majority vote,
// break detection and a valid/ready holding register with sticky overrun.
`timescale 1ns/1ps
module uart_rx_ext #(
  parameter int DATA_BITS = 8,
  parameter int SB_TICKS  = 16,
  parameter int STOP_BITS = 1,
  parameter int PARITY    = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_tick,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic                 rx_valid,
  output logic                 rx_done_tick,
  output logic [DATA_BITS-1:0] dout,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun
);
  localparam int SW = $clog2(SB_TICKS);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_HIGH} state_t;
  state_t state;
  logic rx_m, rx_s;
  logic [SW-1:0] s;
  logic [3:0] n;
  logic [DATA_BITS-1:0] data;
  logic [1:0] smp;
  logic par_bit, p_err, f_err, brk;
  logic bit_v, last_tick, done, load, fe_now, brk_now;
  // the third vote sample is rx_s itself on the deciding tick
  assign bit_v     = (smp[0] & smp[1]) | (smp[0] & rx_s) | (smp[1] & rx_s);
  assign last_tick = s_tick && s == SW'(SB_TICKS-1);
  assign done      = state == STOP && last_tick && n == 4'(STOP_BITS-1);
  assign load      = done && (!rx_valid || rx_ready);
  assign fe_now    = f_err | ~bit_v;
  assign brk_now   = n == 4'd0 ? (data == '0 && !par_bit && !bit_v) : brk;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      s       <= '0;
      n       <= '0;
      data    <= '0;
      smp     <= '0;
      par_bit <= 1'b0;
      p_err   <= 1'b0;
      f_err   <= 1'b0;
      brk     <= 1'b0;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      case (state)
        IDLE: if (!rx_s) begin
          state <= START;
          s     <= '0;
        end
        START: if (s_tick) begin
          if (s == SW'(SB_TICKS/2-1)) begin
            if (rx_s) state <= IDLE;
            else begin
              state   <= DATA;
              s       <= '0;
              n       <= '0;
              par_bit <= 1'b0;
              p_err   <= 1'b0;
              f_err   <= 1'b0;
              brk     <= 1'b0;
            end
          end else s <= s + 1'b1;
        end
        WAIT_HIGH: if (rx_s) state <= IDLE;
        default: if (s_tick) begin
          s <= last_tick ? '0 : s + 1'b1;
          if (s == SW'(SB_TICKS-3)) smp[0] <= rx_s;
          if (s == SW'(SB_TICKS-2)) smp[1] <= rx_s;
          if (last_tick) begin
            if (state == DATA) begin
              data <= {bit_v, data[DATA_BITS-1:1]};
              if (n == 4'(DATA_BITS-1)) begin
                n <= '0;
                if (PARITY != 0) state <= PAR;
                else state <= STOP;
              end else n <= n + 1'b1;
            end else if (state == PAR) begin
              par_bit <= bit_v;
              p_err   <= (^data ^ bit_v) != (PARITY == 2);
              state   <= STOP;
            end else begin
              f_err <= fe_now;
              brk   <= brk_now;
              if (done) begin
                n <= '0;
                if (bit_v) state <= IDLE;
                else state <= WAIT_HIGH;
              end else n <= n + 1'b1;
            end
          end
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_valid     <= 1'b0;
      rx_done_tick <= 1'b0;
      dout         <= '0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      break_det    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      rx_done_tick <= load;
      if (load) begin
        dout       <= data;
        parity_err <= p_err;
        frame_err  <= fe_now;
        break_det  <= brk_now;
        rx_valid   <= 1'b1;
      end else if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (done && !load) overrun <= 1'b1;
      else if (rx_valid && rx_ready) overrun <= 1'b0;
    end
  end
endmodule
